hex_display_scanner: RTL and testbench
======================================

# hex_display_scanner

Time-multiplexed driver for an 8-digit common-anode seven-segment display. It sits directly downstream of `master` and consumes its 32-bit `debug_hex_display` word, showing it as 8 hex digits. The input is snapshotted once per scan frame so a digit never changes mid-frame (no tearing), and leading zeros can optionally be blanked. All outputs are registered and active-low, so they can drive board pins directly.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit is lit; legal range 2..2^20.
- `external_clk`  in  1  system clock; every register updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  scan enable; when low, scanning freezes and the display is dark.
- `value`  in  32  word to display; nibble k drives digit k (digit 0 is least significant, rightmost).
- `blank_leading`  in  1  when 1, suppress leading zero digits.
- `seg_n`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `an_n`  out  8  digit anodes, one-hot active-low; bit k selects digit k.
- `frame_start`  out  1  one-cycle pulse on each cycle where the shadow register loads.

## Operation
- **State registers**
  - `div_cnt`: 20 bits.
  - `digit_idx`: 3 bits.
  - `shadow`: 32 bits.
  - `load_pending`: 1 bit.
- **Reset values**
  - `div_cnt`=0, `digit_idx`=0, `shadow`=0, `load_pending`=1.
  - `seg_n`=7'h7F, `an_n`=8'hFF, `frame_start`=0.
- **Tick:** `tick` = `ena` && `div_cnt`==REFRESH_DIV-1. On tick, `div_cnt` wraps to 0; otherwise it increments while `ena` is high.
- **Digit stepping:** on tick, `digit_idx` increments mod 8, wrapping 7 to 0.
- **Shadow load:** `shadow` <= `value` when `ena` && (`load_pending` || (tick && `digit_idx`==7)).
  - `load_pending` clears on that load.
  - `frame_start` is registered high for exactly that cycle.
- **Output decode (registered):** each enabled edge samples the current `digit_idx`/`shadow`.
  - `an_n` = ~(1<<`digit_idx`); `seg_n` = font(`shadow[4*digit_idx+:4]`).
  - If the digit is blanked: `an_n`=8'hFF, `seg_n`=7'h7F.
- **Blanking rule:** digit k (1..7) is blanked iff `blank_leading` && `shadow[31:4k]`==0. Digit 0 is never blanked, so value 0 shows a single "0".
- **Font** (hex nibble -> `seg_n`):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- **`ena` low**
  - `div_cnt`, `digit_idx`, `shadow` and `load_pending` hold.
  - On the next edge: `an_n`=8'hFF, `seg_n`=7'h7F, `frame_start`=0.
  - When `ena` returns, scanning resumes with the same digit and remaining count.
- **`value` changes** mid-frame are ignored until the next frame load; the new word first appears on digit 0 of the next frame.

## Timing
- The outputs lag the state registers by one cycle.
- **First enabled edge after reset**
  - Loads `shadow`, and `frame_start`=1 for that cycle.
  - Outputs still show dark/`shadow`=0 decode (digit 0 → `seg_n`=40, `an_n`=FE).
- **Second enabled edge:** outputs show digit 0 of the loaded value.
- **Digit slots:** each digit occupies exactly REFRESH_DIV cycles; one frame is 8·REFRESH_DIV cycles.
- **Frame boundary:** the tick leaving digit 7 loads `shadow`, pulses `frame_start` and moves to digit 0 on the same edge. The following edge outputs digit 0 of the new value.
- **Reset mid-scan:** outputs go dark immediately (asynchronously), and the sequence restarts from the first-enabled-edge behaviour.
- **`ena` asserted on a terminal-count cycle:** tick occurs normally.

## Test plan
- **Basic scan.** REFRESH_DIV=4, `ena`=1, `value`=32'h1234ABCD, `blank_leading`=0, release reset.
  - `frame_start` pulses once.
  - Digit 0: `an_n`=FE, `seg_n`=21 for 4 cycles.
  - Then FD/46, FB/03, F7/08, EF/19, DF/30, BF/24, 7F/79.
  - Then digit 0 repeats, with a `frame_start` pulse every 32 cycles.
- **Leading-zero blanking.** `value`=32'h000000A5, `blank_leading`=1.
  - Digit 0 shows 12; digit 1 shows 08.
  - Digits 2–7 give `an_n`=FF, `seg_n`=7F in their slots.
  - `value`=0 shows only digit 0 = 40.
- **Tear-free update.** Change `value` from 32'h11111111 to 32'h22222222 while digit 3 is lit.
  - Digits 3–7 still show 79.
  - The first 24 appears on digit 0 right after the next `frame_start`.
- **Enable freeze.** Drop `ena` for 10 cycles after 2 cycles into digit 5's slot.
  - Next edge: `an_n`=FF, `seg_n`=7F.
  - On re-enable, digit 5 is lit for its remaining 2 cycles, then digit 6.
- **Reset mid-scan.** Assert `rst` asynchronously between edges during digit 6.
  - `an_n`=FF and `seg_n`=7F immediately.
  - After release, the sequence matches the basic-scan startup, including the `frame_start` on the first edge.
- **Minimum divider.** REFRESH_DIV=2: each digit is lit 2 cycles, and the frame is 16 cycles.

Source files
------------

// File: rtl/hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_scanner
// Brief    : Time-multiplexed 8-digit common-anode hex display driver with
//            per-frame snapshot of the input word and leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_scanner #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        external_clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [31:0] value,
    input  logic        blank_leading,
    output logic [6:0]  seg_n,
    output logic [7:0]  an_n,
    output logic        frame_start
);

    localparam logic [19:0] c_div_last = 20'(REFRESH_DIV - 1);
    localparam logic [6:0]  c_seg_off  = 7'h7F;
    localparam logic [7:0]  c_an_off   = 8'hFF;

    logic [19:0] r_div_cnt;
    logic [2:0]  r_digit_idx;
    logic [31:0] r_shadow;
    logic        r_load_pending;

    logic        w_tick;
    logic        w_load;
    logic [3:0]  w_nibble;
    logic [31:0] w_upper;
    logic        w_blank;
    logic [6:0]  w_font;

    assign w_tick   = ena && (r_div_cnt == c_div_last);
    assign w_load   = ena && (r_load_pending || (w_tick && (r_digit_idx == 3'd7)));
    assign w_nibble = r_shadow[{r_digit_idx, 2'b00} +: 4];
    // Everything from the current digit upward; zero means this digit is a leading zero.
    assign w_upper  = r_shadow >> {r_digit_idx, 2'b00};
    assign w_blank  = blank_leading && (r_digit_idx != 3'd0) && (w_upper == 32'd0);

    always_comb begin
        w_font = c_seg_off;
        case (w_nibble)
            4'h0: w_font = 7'h40;
            4'h1: w_font = 7'h79;
            4'h2: w_font = 7'h24;
            4'h3: w_font = 7'h30;
            4'h4: w_font = 7'h19;
            4'h5: w_font = 7'h12;
            4'h6: w_font = 7'h02;
            4'h7: w_font = 7'h78;
            4'h8: w_font = 7'h00;
            4'h9: w_font = 7'h10;
            4'hA: w_font = 7'h08;
            4'hB: w_font = 7'h03;
            4'hC: w_font = 7'h46;
            4'hD: w_font = 7'h21;
            4'hE: w_font = 7'h06;
            4'hF: w_font = 7'h0E;
            default: w_font = c_seg_off;
        endcase
    end

    always_ff @(posedge external_clk or posedge rst) begin
        if (rst) begin
            r_div_cnt      <= 20'd0;
            r_digit_idx    <= 3'd0;
            r_shadow       <= 32'd0;
            r_load_pending <= 1'b1;
            seg_n          <= c_seg_off;
            an_n           <= c_an_off;
            frame_start    <= 1'b0;
        end else begin
            frame_start <= w_load;
            if (ena) begin
                r_div_cnt <= w_tick ? 20'd0 : r_div_cnt + 20'd1;
                if (w_tick) begin
                    r_digit_idx <= r_digit_idx + 3'd1;
                end
                if (w_load) begin
                    r_shadow       <= value;
                    r_load_pending <= 1'b0;
                end
                seg_n <= w_blank ? c_seg_off : w_font;
                an_n  <= w_blank ? c_an_off  : ~(8'b1 << r_digit_idx);
            end else begin
                seg_n <= c_seg_off;
                an_n  <= c_an_off;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_scanner
// Brief    : Bench for hex_display_scanner at dividers 4 and 2 against a
//            position-based arithmetic model of the scan sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_scanner;

    logic        external_clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [31:0] value;
    logic        blank_leading;
    logic [6:0]  seg_a, seg_b;
    logic [7:0]  an_a, an_b;
    logic        fs_a, fs_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 external_clk = ~external_clk;

    hex_display_scanner #(.REFRESH_DIV(4)) dut_a (
        .external_clk (external_clk), .rst (rst), .ena (ena), .value (value),
        .blank_leading(blank_leading), .seg_n (seg_a), .an_n (an_a), .frame_start (fs_a)
    );

    hex_display_scanner #(.REFRESH_DIV(2)) dut_b (
        .external_clk (external_clk), .rst (rst), .ena (ena), .value (value),
        .blank_leading(blank_leading), .seg_n (seg_b), .an_n (an_b), .frame_start (fs_b)
    );

    // Model: p counts enabled edges since reset; the digit on screen and the
    // frame boundaries follow from p and the divider by plain arithmetic.
    int unsigned     c_div [2] = '{4, 2};
    logic [6:0]      font  [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    longint unsigned m_p      [2];
    logic [31:0]     m_shadow [2];
    logic [6:0]      m_seg    [2];
    logic [7:0]      m_an     [2];
    logic            m_fs     [2];

    always @(posedge external_clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            int unsigned dig;
            int unsigned nd;
            longint unsigned frame;
            if (rst) begin
                m_p[d]      <= 0;
                m_shadow[d] <= 32'd0;
                m_seg[d]    <= 7'h7F;
                m_an[d]     <= 8'hFF;
                m_fs[d]     <= 1'b0;
            end else if (ena) begin
                frame = 8 * c_div[d];
                dig   = int'((m_p[d] / c_div[d]) % 8);
                nd    = 1;
                for (int k = 7; k >= 1; k--)
                    if (nd == 1 && m_shadow[d][4*k +: 4] != 4'd0) nd = k + 1;
                if (blank_leading && dig >= nd) begin
                    m_seg[d] <= 7'h7F;
                    m_an[d]  <= 8'hFF;
                end else begin
                    m_seg[d] <= font[m_shadow[d][4*dig +: 4]];
                    m_an[d]  <= ~(8'd1 << dig);
                end
                if (m_p[d] == 0 || (m_p[d] % frame) == frame - 1) begin
                    m_shadow[d] <= value;
                    m_fs[d]     <= 1'b1;
                end else begin
                    m_fs[d]     <= 1'b0;
                end
                m_p[d] <= m_p[d] + 1;
            end else begin
                m_seg[d] <= 7'h7F;
                m_an[d]  <= 8'hFF;
                m_fs[d]  <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("seg_a", 32'(seg_a), 32'(m_seg[0]));
        chk("an_a",  32'(an_a),  32'(m_an[0]));
        chk("fs_a",  32'(fs_a),  32'(m_fs[0]));
        chk("seg_b", 32'(seg_b), 32'(m_seg[1]));
        chk("an_b",  32'(an_b),  32'(m_an[1]));
        chk("fs_b",  32'(fs_b),  32'(m_fs[1]));
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge external_clk);
            check_model();
        end
    endtask

    task automatic check_dark(input string tag);
        chk({tag, "_seg"}, 32'(seg_a), 32'h7F);
        chk({tag, "_an"},  32'(an_a),  32'hFF);
        chk({tag, "_fs"},  32'(fs_a),  32'h0);
    endtask

    task automatic check_startup();
        run(1);
        chk("start_fs",  32'(fs_a),  32'h1);
        chk("start_seg", 32'(seg_a), 32'h40);
        chk("start_an",  32'(an_a),  32'hFE);
        run(1);
        chk("d0_seg", 32'(seg_a), 32'h21);
        chk("d0_an",  32'(an_a),  32'hFE);
        chk("d0_fs",  32'(fs_a),  32'h0);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; value = 32'h1234ABCD; blank_leading = 1'b0;
        #1 check_dark("reset");
        repeat (2) @(negedge external_clk);
        check_dark("reset_hold");
        rst = 1'b0;

        // Basic scan over two frames
        check_startup();
        run(70);

        // Leading-zero blanking, then the all-zero word
        value = 32'h000000A5; blank_leading = 1'b1;
        run(80);
        value = 32'h00000000;
        run(40);
        blank_leading = 1'b0;

        // Tear-free update: change the word while digit 3 is lit
        value = 32'h11111111;
        run(40);
        for (int i = 0; i < 40 && (m_p[0] % 32) != 13; i++) run(1);
        value = 32'h22222222;
        run(50);

        // Enable freeze two cycles into digit 5
        for (int i = 0; i < 40 && (m_p[0] % 32) != 22; i++) run(1);
        ena = 1'b0;
        run(1);
        check_dark("freeze");
        run(9);
        ena = 1'b1;
        run(30);

        // Asynchronous reset during digit 6
        value = 32'h1234ABCD;
        for (int i = 0; i < 40 && (m_p[0] % 32) != 25; i++) run(1);
        #2 rst = 1'b1;
        #1 check_dark("async_rst");
        run(2);
        rst = 1'b0;
        check_startup();
        run(40);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            run(1);
            if ($urandom_range(0, 19) == 0) value = $urandom;
            if ($urandom_range(0, 3) == 0) value = value & (32'hFFFFFFFF >> (4 * $urandom_range(0, 7)));
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) blank_leading = ~blank_leading;
        end
        run(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
